booth_arbiter: RTL and testbench
================================

Name: booth_arbiter

Overview:
Shares one 8-bit serial Booth multiplier core among NREQ requesters using round-robin arbitration.
- Accepts signed operand pairs per requester over valid/ready.
- Sequences the core's byte-serial protocol: multiplicand, then multiplier on the in-bus; high byte, then low byte on the out-bus.
- Returns the 16-bit signed product to the granted requester.
- A watchdog converts a hung core into an error response.

Parameters:
NREQ, 2, number of requesters (2..8)
TIMEOUT, 32, max cycles in BUSY waiting for mul_done before error

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  request pending, per requester
req_ready  out  NREQ  one-hot acceptance pulse
req_a  in  NREQ*8  signed multiplicand, slice i for requester i
req_b  in  NREQ*8  signed multiplier, slice i
rsp_valid  out  NREQ  one-hot response valid
rsp_ready  in  NREQ  response accept, per requester
rsp_product  out  16  signed product {hi,lo}, shared
rsp_err  out  1  qualified by rsp_valid; 1 = core timeout
mul_enable  out  1  core start strobe
mul_inbus  out  8  operand bus to core
mul_done  in  1  core finished
mul_outbus  in  8  result bus from core

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE.
  - All outputs 0: req_ready, rsp_valid, rsp_product, rsp_err, mul_enable, mul_inbus.
  - RR pointer = NREQ-1, so requester 0 has highest priority first.
  - Watchdog counter = 0.
- Reset mid-operation aborts the transaction silently: no response is issued, and the requester must re-request.
- FSM states: IDLE, LOAD_M, LOAD_Q, BUSY, READ_LO, RESP.
- IDLE:
  - If any req_valid is set, grant g = first set bit scanning from ptr+1 upward, modulo NREQ.
  - req_ready[g]=1 combinationally in this cycle only.
  - Latch req_a[g], req_b[g] and g; go to LOAD_M.
  - No request: stay.
- LOAD_M (1 cycle): mul_enable=1, mul_inbus=latched a. Go to LOAD_Q.
- LOAD_Q (1 cycle): mul_enable=0, mul_inbus=latched b. Go to BUSY, clear watchdog.
- BUSY:
  - mul_inbus=0; watchdog increments each cycle.
  - mul_done=1: capture mul_outbus as hi byte, go to READ_LO.
  - Else if watchdog==TIMEOUT-1: set err, product=0, go to RESP.
  - mul_done takes precedence over timeout in the same cycle.
- READ_LO (1 cycle): capture mul_outbus as lo byte; err=0; go to RESP.
- RESP:
  - rsp_valid[g]=1; rsp_product and rsp_err are held stable.
  - On rsp_ready[g]=1: go to IDLE, ptr=g.
  - Backpressure is unbounded; no new grant is issued while in RESP.
  - rsp_ready on any non-granted lane is ignored.
- Latency, request accept to rsp_valid with no timeout: 4 cycles plus core busy cycles (IDLE→LOAD_M→LOAD_Q→BUSY..done→READ_LO→RESP).
- Width rules:
  - Operands are two's-complement 8-bit; the product is 16-bit two's complement formed by the core.
  - The arbiter performs no arithmetic other than the watchdog counter ($clog2(TIMEOUT) bits, saturating never reached).
- A req_valid drop before grant is allowed. Once req_ready pulses, the operands are owned by the arbiter.
- mul_done outside BUSY is ignored.
- Only one transaction is in flight at a time; there is no operand queueing.

Decomposition:
- Package booth_arb_pkg:
  - state_t enum (IDLE, LOAD_M, LOAD_Q, BUSY, READ_LO, RESP).
  - OPW=8, PRODW=16.
- Sub-module rr_arbiter #(NREQ):
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, grant index, any_req.
  - Purely combinational priority rotate.
- FSM, operand/result registers and watchdog stay in booth_arbiter.

Test Plan:
- Req0 a=3, b=5 with behavioural core model (done after 9 cycles, hi then lo) → LOAD_M shows mul_enable=1 and inbus=0x03; LOAD_Q shows inbus=0x05; rsp_valid[0] with product=0x000F, err=0.
- Req1 a=-3 (0xFD), b=7 → product=0xFFEB (-21); a=-128, b=-128 → product=0x4000.
- Req0 and req1 both held valid for 3 transactions → grant order 0,1,0; req_ready is exactly one 1-cycle pulse per grant.
- Core model never asserts done, TIMEOUT=32 → rsp_valid exactly 32 cycles after entering BUSY, rsp_err=1, product=0; next request proceeds normally.
- rsp_ready held low 10 cycles → rsp_valid and product stable; req0 waiting is not granted until rsp_ready[1]=1.
- rst_n low for 1 cycle mid-BUSY → all outputs 0 immediately (async); next request is granted to requester 0 and completes correctly.

Source files
------------

// File: rtl/booth_arb_pkg.sv
// Shared types and widths for the Booth multiplier arbiter.
// The state encoding and operand/product widths are common to the top and its testbench.
package booth_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_M,
    LOAD_Q,
    BUSY,
    READ_LO,
    RESP
  } state_t;

  localparam int OPW   = 8;
  localparam int PRODW = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester above ptr, wrapping modulo NREQ.
// The requester at ptr itself has the lowest priority.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx,
  output logic                    any_req
);

  localparam int IW = $clog2(NREQ);

  always_comb begin : pick
    logic [IW-1:0] idx;
    logic          found;
    grant     = '0;
    grant_idx = '0;
    any_req   = |req;
    found     = 1'b0;
    idx       = '0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = IW'((int'(ptr) + off) % NREQ);
      if (!found && req[idx]) begin
        found          = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/booth_arbiter.sv
// Round-robin front end sharing one byte-serial Booth multiplier core among NREQ requesters.
// Sequences operand load, waits for the core under a watchdog, and returns {hi,lo} or an error.
module booth_arbiter
  import booth_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*OPW-1:0] req_a,
  input  logic [NREQ*OPW-1:0] req_b,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [PRODW-1:0]    rsp_product,
  output logic                rsp_err,
  output logic                mul_enable,
  output logic [OPW-1:0]      mul_inbus,
  input  logic                mul_done,
  input  logic [OPW-1:0]      mul_outbus
);

  localparam int IW  = $clog2(NREQ);
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t            state_reg, state_next;
  logic [IW-1:0]     ptr_reg, g_reg;
  logic [OPW-1:0]    a_reg, b_reg, hi_reg;
  logic [WDW-1:0]    wd_reg;
  logic [PRODW-1:0]  product_reg;
  logic              err_reg;

  logic [NREQ-1:0]   grant;
  logic [IW-1:0]     grant_idx;
  logic              any_req;
  logic              wd_expired;

  logic [OPW-1:0]    a_lane [NREQ];
  logic [OPW-1:0]    b_lane [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
    assign a_lane[gi]    = req_a[gi*OPW +: OPW];
    assign b_lane[gi]    = req_b[gi*OPW +: OPW];
    assign rsp_valid[gi] = (state_reg == RESP) && (g_reg == IW'(gi));
  end

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req       (req_valid),
    .ptr       (ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  assign wd_expired  = (wd_reg == WDW'(TIMEOUT - 1));
  assign rsp_product = product_reg;
  assign rsp_err     = err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // req_ready is gated by rst_n so no acceptance can be signalled while held in reset.
  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    mul_enable = 1'b0;
    mul_inbus  = '0;
    case (state_reg)
      IDLE: begin
        if (any_req && rst_n) begin
          req_ready  = grant;
          state_next = LOAD_M;
        end
      end
      LOAD_M: begin
        mul_enable = 1'b1;
        mul_inbus  = a_reg;
        state_next = LOAD_Q;
      end
      LOAD_Q: begin
        mul_inbus  = b_reg;
        state_next = BUSY;
      end
      BUSY: begin
        if (mul_done)        state_next = READ_LO;
        else if (wd_expired) state_next = RESP;
      end
      READ_LO: state_next = RESP;
      RESP: begin
        if (rsp_ready[g_reg]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg     <= IW'(NREQ - 1);
      g_reg       <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      hi_reg      <= '0;
      wd_reg      <= '0;
      product_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            a_reg <= a_lane[grant_idx];
            b_reg <= b_lane[grant_idx];
            g_reg <= grant_idx;
          end
        end
        LOAD_Q: wd_reg <= '0;
        BUSY: begin
          wd_reg <= wd_reg + 1'b1;
          // A done in the expiry cycle still wins: the core result is taken.
          if (mul_done) begin
            hi_reg <= mul_outbus;
          end else if (wd_expired) begin
            product_reg <= '0;
            err_reg     <= 1'b1;
          end
        end
        READ_LO: begin
          product_reg <= {hi_reg, mul_outbus};
          err_reg     <= 1'b0;
        end
        RESP: begin
          if (rsp_ready[g_reg]) ptr_reg <= g_reg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_arbiter.sv
// Randomized self-checking bench for booth_arbiter with a behavioural byte-serial core.
// A transaction-level model predicts grants, latencies, products and errors.
module tb_booth_arbiter;

  localparam int NREQ    = 3;
  localparam int TIMEOUT = 32;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*8-1:0]   req_a, req_b;
  logic [15:0]         rsp_product;
  logic                rsp_err, mul_enable;
  logic [7:0]          mul_inbus;
  logic                mul_done = 1'b0;
  logic [7:0]          mul_outbus = 8'h00;

  always #5 clk = ~clk;

  booth_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_product (rsp_product),
    .rsp_err     (rsp_err),
    .mul_enable  (mul_enable),
    .mul_inbus   (mul_inbus),
    .mul_done    (mul_done),
    .mul_outbus  (mul_outbus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Behavioural core: multiplicand on the enable strobe, multiplier next cycle,
  // done (with hi byte) in BUSY cycle core_k, lo byte on the following cycle.
  int  core_k    = 9;
  bit  core_hang = 1'b0;
  int  cstate, ccnt;
  byte ca, cb;
  logic [15:0] cprod;
  assign cprod = 16'(int'(ca) * int'(cb));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cstate     <= 0;
      mul_done   <= 1'b0;
      mul_outbus <= 8'h00;
    end else begin
      mul_done <= 1'b0;
      if (mul_enable) begin
        ca     <= mul_inbus;
        cstate <= 1;
      end else begin
        case (cstate)
          1: begin cb <= mul_inbus; ccnt <= 0; cstate <= 2; end
          2: if (!core_hang) begin
               if (ccnt == core_k - 2) begin
                 mul_done   <= 1'b1;
                 mul_outbus <= cprod[15:8];
                 cstate     <= 3;
               end else ccnt <= ccnt + 1;
             end
          3: begin mul_outbus <= cprod[7:0]; cstate <= 0; end
          default: ;
        endcase
      end
    end
  end

  // Transaction-level reference state.
  logic [15:0] lane_q [NREQ][$];
  bit          busy = 1'b0;
  int          g = 0, acc_cyc = 0, lat = 0, model_ptr = NREQ - 1;
  int          resp_seen = 0, stall_n = 0, rdy_pct = 100, hold_pct = 0, n_txn = 0;
  bit          rand_core = 1'b0;
  logic [15:0] cur_op, exp_prod, last_prod;
  bit          exp_err, last_err;
  int          grant_log [$];

  // Next grant: lowest pending index above the last winner, else lowest pending overall.
  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    int lo = -1, hi = -1;
    for (int i = 0; i < NREQ; i++)
      if (v[i]) begin
        if (lo < 0) lo = i;
        if (i > p && hi < 0) hi = i;
      end
    return (hi >= 0) ? hi : lo;
  endfunction

  function automatic bit pending();
    for (int i = 0; i < NREQ; i++) if (lane_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (lane_q[i].size() > 0 && !(hold_pct > 0 && $urandom_range(0, 99) < hold_pct)) begin
        req_valid[i]     = 1'b1;
        req_a[i*8 +: 8]  = lane_q[i][0][15:8];
        req_b[i*8 +: 8]  = lane_q[i][0][7:0];
      end else begin
        req_valid[i]     = 1'b0;
        req_a[i*8 +: 8]  = 8'($urandom);
        req_b[i*8 +: 8]  = 8'($urandom);
      end
      if (busy && i == g)
        rsp_ready[i] = (resp_seen >= stall_n) && ($urandom_range(0, 99) < rdy_pct);
      else
        rsp_ready[i] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic sample();
    logic [NREQ-1:0] exp_rr, exp_rv;
    int ph, sel;
    byte sa, sb;
    exp_rr = '0;
    exp_rv = '0;
    sel    = -1;
    if (!rst_n) begin
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_product", rsp_product, 0);
      check("rst_err", rsp_err, 0);
      check("rst_mul_enable", mul_enable, 0);
      check("rst_mul_inbus", mul_inbus, 0);
      return;
    end
    if (!busy) begin
      if (req_valid != '0) begin
        sel    = pick(req_valid, model_ptr);
        exp_rr = NREQ'(1) << sel;
      end
    end else begin
      ph = cyc - acc_cyc;
      if (ph >= lat) exp_rv = NREQ'(1) << g;
      if (ph == 1) begin
        check("load_m_enable", mul_enable, 1);
        check("load_m_inbus", mul_inbus, cur_op[15:8]);
      end
      if (ph == 2) begin
        check("load_q_enable", mul_enable, 0);
        check("load_q_inbus", mul_inbus, cur_op[7:0]);
      end
      if (ph == 3) check("busy_inbus", mul_inbus, 0);
    end
    check("req_ready", req_ready, exp_rr);
    check("rsp_valid", rsp_valid, exp_rv);
    if (exp_rv != '0) begin
      check("rsp_product", rsp_product, exp_prod);
      check("rsp_err", rsp_err, exp_err);
      resp_seen++;
      if (rsp_ready[g]) begin
        busy      = 1'b0;
        model_ptr = g;
        stall_n   = 0;
        last_prod = rsp_product;
        last_err  = rsp_err;
        n_txn++;
        $display("txn %0d: lane %0d a=%0d b=%0d product=0x%04h err=%0b latency=%0d",
                 n_txn, g, $signed(cur_op[15:8]), $signed(cur_op[7:0]), rsp_product, rsp_err, lat);
      end
    end else if (sel >= 0) begin
      g      = sel;
      cur_op = lane_q[g].pop_front();
      grant_log.push_back(g);
      if (rand_core) begin
        core_k    = $urandom_range(2, 12);
        core_hang = ($urandom_range(0, 9) == 0);
      end
      sa        = cur_op[15:8];
      sb        = cur_op[7:0];
      exp_err   = core_hang;
      exp_prod  = core_hang ? 16'h0000 : 16'(int'(sa) * int'(sb));
      lat       = core_hang ? 3 + TIMEOUT : 4 + core_k;
      acc_cyc   = cyc;
      resp_seen = 0;
      busy      = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1 drive();
    @(negedge clk);
    sample();
  endtask

  task automatic run_until_idle(input int max);
    int n = 0;
    while ((busy || pending()) && n < max) begin
      step();
      n++;
    end
    check("drain", busy || pending(), 0);
  endtask

  task automatic wait_phase(input int ph, input int max);
    int n = 0;
    while (!(busy && (cyc - acc_cyc) >= ph) && n < max) begin
      step();
      n++;
    end
    check("wait_phase", busy && (cyc - acc_cyc) >= ph, 1);
  endtask

  // Asynchronous reset for one cycle, entered just after a sampling edge.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    check("async_req_ready", req_ready, 0);
    check("async_rsp_valid", rsp_valid, 0);
    check("async_product", rsp_product, 0);
    check("async_err", rsp_err, 0);
    check("async_mul_enable", mul_enable, 0);
    check("async_mul_inbus", mul_inbus, 0);
    if (busy) begin
      lane_q[g].push_front(cur_op);
      busy = 1'b0;
    end
    model_ptr = NREQ - 1;
    @(posedge clk);
    cyc++;
    #1 drive();
    #2 rst_n = 1'b1;
    @(negedge clk);
    sample();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    int idx;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '0;
    repeat (3) step();
    rst_n = 1'b1;

    // 3 * 5 on lane 0 with a 9-cycle core
    core_k = 9;
    lane_q[0].push_back({8'd3, 8'd5});
    run_until_idle(200);
    check("prod_3x5", last_prod, 16'h000F);
    check("err_3x5", last_err, 0);

    // Signed operands on lane 1
    lane_q[1].push_back({8'hFD, 8'd7});
    run_until_idle(200);
    check("prod_m3x7", last_prod, 16'hFFEB);
    lane_q[1].push_back({8'h80, 8'h80});
    run_until_idle(200);
    check("prod_m128sq", last_prod, 16'h4000);

    // Both lanes continuously valid: alternating grants
    grant_log.delete();
    for (int i = 0; i < 2; i++) begin
      lane_q[0].push_back(16'($urandom));
      lane_q[1].push_back(16'($urandom));
    end
    run_until_idle(400);
    check("order_0", grant_log[0], 0);
    check("order_1", grant_log[1], 1);
    check("order_2", grant_log[2], 0);

    // Hung core: watchdog error, then normal recovery
    core_hang = 1'b1;
    lane_q[0].push_back(16'($urandom));
    run_until_idle(300);
    check("timeout_err", last_err, 1);
    check("timeout_prod", last_prod, 0);
    core_hang = 1'b0;
    lane_q[0].push_back({8'd11, 8'hF6});
    run_until_idle(200);
    check("recover_prod", last_prod, 16'hFF92);

    // Done in the final watchdog cycle beats the timeout
    core_k = TIMEOUT;
    lane_q[1].push_back({8'd100, 8'd100});
    run_until_idle(300);
    check("edge_err", last_err, 0);
    check("edge_prod", last_prod, 16'h2710);
    core_k = 9;

    // Response backpressure with a competing requester waiting
    lane_q[1].push_back(16'($urandom));
    wait_phase(1, 50);
    stall_n = 10;
    lane_q[0].push_back(16'($urandom));
    run_until_idle(400);

    // Reset in the middle of BUSY aborts lane 1; lane 0 wins afterwards
    lane_q[1].push_back(16'($urandom));
    wait_phase(5, 50);
    lane_q[0].push_back({8'hF9, 8'hF9});
    idx = grant_log.size();
    pulse_reset();
    run_until_idle(400);
    check("post_reset_grant", grant_log[idx], 0);

    // Randomized traffic
    rand_core = 1'b1;
    hold_pct  = 20;
    rdy_pct   = 60;
    for (int t = 0; t < 40; t++)
      lane_q[$urandom_range(0, NREQ - 1)].push_back(16'($urandom));
    run_until_idle(8000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
